// File: rtl/boot_rom_arbiter.sv
// Purpose : shares one combinational boot ROM between instruction fetch (port 0)
//           and debug/data (port 1); writes and out-of-window reads get an error.
// Latency : grant in the request cycle; response (rvalid/rdata/err) one cycle later.
// Backpressure: none; requesters must take rvalid in the cycle it is asserted.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_i[p], we_i[p]    request / write enable of port p
//   addr_i[p]            byte address of port p (low 3 bits ignored)
//   gnt_o[p]             combinational grant
//   rvalid_o[p]          one-cycle response strobe, the cycle after the grant
//   rdata_o[p], err_o[p] response data / error, held while rvalid_o[p] is low
//   rom_addr_o           doubleword-aligned address to the ROM (0 when idle)
//   rom_data_i           ROM read data for rom_addr_o
module boot_rom_arbiter #(
  parameter logic [63:0] ROM_BASE = 64'h1000,
  parameter int unsigned ROM_SIZE = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [1:0][63:0] addr_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       rvalid_o,
  output logic [1:0][63:0] rdata_o,
  output logic [1:0]       err_o,
  output logic [63:0]      rom_addr_o,
  input  logic [63:0]      rom_data_i
);

  // Window bounds in 65 bits so BASE+SIZE can never wrap to a small value.
  localparam logic [64:0] WIN_LO = {1'b0, ROM_BASE};
  localparam logic [64:0] WIN_HI = {1'b0, ROM_BASE} + 65'(ROM_SIZE);

  logic             prio_q, prio_d;
  logic [1:0]       rvalid_q;
  logic [1:0]       err_q, err_d;
  logic [1:0][63:0] rdata_q, rdata_d;

  logic [1:0]       gnt;
  logic             gnt_any;
  logic             gnt_idx;
  logic [63:0]      gnt_addr;
  logic [64:0]      gnt_addr_w;
  logic             in_range;
  logic             reject;

  // Arbitration: a lone requester wins; on contention the pointer decides.
  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (!rst_i) begin
      unique case (req_i)
        2'b01: begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_idx = prio_q;
          gnt     = prio_q ? 2'b10 : 2'b01;
        end
        default: begin
          gnt     = 2'b00;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

  assign gnt_any = |gnt;
  assign gnt_o   = gnt;

  // Address to the ROM: granted address aligned to 8 bytes, 0 when idle.
  assign gnt_addr   = gnt_any ? (addr_i[gnt_idx] & ~64'h7) : 64'h0;
  assign rom_addr_o = gnt_addr;

  assign gnt_addr_w = {1'b0, gnt_addr};
  assign in_range   = (gnt_addr_w >= WIN_LO) && (gnt_addr_w < WIN_HI);
  assign reject     = we_i[gnt_idx] | ~in_range;

  // Only a contested grant moves the pointer, toward the loser.
  always_comb begin
    prio_d = prio_q;
    if (gnt_any && (req_i == 2'b11)) begin
      prio_d = ~gnt_idx;
    end
  end

  // Response capture. Rejected accesses return constant zero data, so any
  // X from the ROM never reaches a requester on an error response; in-range
  // data is passed through untouched.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (gnt_any) begin
      if (reject) begin
        rdata_d[gnt_idx] = 64'h0;
        err_d[gnt_idx]   = 1'b1;
      end else begin
        rdata_d[gnt_idx] = rom_data_i;
        err_d[gnt_idx]   = 1'b0;
      end
    end
  end

  // Reset clears rvalid_q, so a response pending from a grant in the cycle
  // reset arrives is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q   <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '0;
    end else begin
      prio_q   <= prio_d;
      rvalid_q <= gnt;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
- Shares the single combinational boot ROM (64-bit address in, 64-bit data out) between two requesters: port 0 is instruction fetch and port 1 is the debug/data port.
- Each port uses a req/gnt/rvalid handshake. Grant is same-cycle; the response arrives one cycle after the grant.
- Sits between the core/debug interconnect and the ROM. It also filters writes and out-of-range accesses, which it answers with an error response.

Parameters:
- ROM_BASE, 64'h1000, byte base address of the ROM window.
- ROM_SIZE, 32, ROM window size in bytes. Must be a multiple of 8.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- req_i  input  2  request, bit p belongs to port p
- we_i  input  2  write enable per port; always rejected
- addr_i  input  2x64  byte address per port
- gnt_o  output  2  grant per port
- rvalid_o  output  2  response valid per port
- rdata_o  output  2x64  response data per port
- err_o  output  2  response error per port, valid with rvalid_o
- rom_addr_o  output  64  address driven to the ROM
- rom_data_i  input  64  ROM read data

Behaviour:
- Reset (asynchronous, rst_i=1):
  - rvalid_o=0, err_o=0, rdata_o=0.
  - Priority pointer prio=0 (port 0 favoured).
  - gnt_o is combinational, so it is 0 whenever rst_i=1.
- Arbitration (combinational, every cycle):
  - If only one port requests, that port is granted.
  - If both request, port prio is granted.
  - At most one gnt_o bit is high per cycle.
  - gnt_o[p] may only be high when req_i[p] is high.
- Pointer update (at the clock edge):
  - On a grant while both ports were requesting, prio becomes the index of the non-granted port.
  - On a single-requester grant, or when there is no request, prio is unchanged.
- ROM address:
  - rom_addr_o = granted port's addr_i with bits [2:0] cleared.
  - With no grant, rom_addr_o holds 0.
- Range check, done in the grant cycle:
  - In range when ROM_BASE <= aligned addr < ROM_BASE + ROM_SIZE.
  - Use a 65-bit compare so that ROM_BASE+ROM_SIZE cannot wrap.
- Response, registered, exactly 1 cycle after the grant:
  - rvalid_o[p]=1 for one cycle for the port granted in the previous cycle.
  - Normal case: rdata_o[p] is rom_data_i sampled at the grant cycle, and err_o[p]=0.
  - If we_i[p]=1 or the address is out of range: rdata_o[p]=0, err_o[p]=1, and the ROM data is ignored.
  - A given cycle has no rvalid_o when the previous cycle had no grant.
- No backpressure: requesters must accept rvalid in the cycle it is asserted.
- Pipelining: a new grant may occur in the same cycle as a response, giving back-to-back throughput of 1 access per cycle.
- Hold values:
  - rdata_o/err_o of a port hold their last value when rvalid_o is low.
  - Exception: rdata_o is reset to 0 by reset.
- Data hygiene: X bits coming from the ROM are passed through unchanged for in-range reads. Out-of-range reads never produce X.
- Request rules:
  - A requester keeps req_i and addr_i stable until granted.
  - A req dropped before grant is simply not served; no state is kept.
- Reset mid-operation: a response pending from the grant cycle is discarded, and no rvalid follows after reset deasserts.
- The block holds no outstanding-transaction state beyond one response register stage.

Test Plan:
- Port 0 only, req addr 64'h1000 -> gnt_o=01 same cycle; next cycle rvalid_o=01, rdata_o[0]=64'h02028593_00000297, err_o[0]=0.
- Port 1 only, addr 64'h100C (unaligned) -> rom_addr_o=64'h1008; next cycle rdata_o[1]=64'h0182b283_f1402573.
- Both ports request continuously, port 0 at 64'h1000 and port 1 at 64'h1018, for 6 cycles:
  - Grants alternate 01,10,01,10,... starting with port 0 after reset.
  - Each rvalid follows its grant by one cycle.
  - Port 1 receives 64'h00000000_80000000.
- Out-of-range and write rejection:
  - Port 0 addr 64'h1020 -> next cycle rvalid_o[0]=1, err_o[0]=1, rdata_o[0]=0.
  - Port 1 we_i=1 at 64'h1000 -> err_o[1]=1, rdata_o[1]=0.
  - Also check addr 64'hFFFF_FFFF_FFFF_FFF8 -> error (no wrap).
- Reset mid-operation: grant port 0, then assert rst_i before the next edge -> rvalid_o stays 0 through and after reset; the next contested grant goes to port 0.
- Back-to-back: port 0 requests 64'h1000, 64'h1008, 64'h1010 on consecutive cycles -> three consecutive rvalid_o[0] pulses with the matching data and no bubbles.
